// File: rtl/modn_counter_pkg.sv
// Shared definitions for the modulo-N up/down counter: direction and mode
// encodings plus the range check used for load values.
package modn_counter_pkg;

    localparam logic DIR_DOWN  = 1'b0;
    localparam logic DIR_UP    = 1'b1;

    localparam logic MODE_WRAP = 1'b0;
    localparam logic MODE_SAT  = 1'b1;

    // True when value lies inside the count range 0..modulus-1.
    function automatic logic modn_legal(input logic [31:0] value, input logic [31:0] modulus);
        return (value < modulus);
    endfunction

endpackage

// File: rtl/modn_next_calc.sv
// Combinational next-count calculation for the modulo-N counter. Computes the
// stepped value in both directions with wrap or saturate behaviour, the
// terminal-count flag and whether the step itself is out of range.
module modn_next_calc
    import modn_counter_pkg::*;
#(
    parameter int WIDTH   = 4,
    parameter int MODULUS = 14,
    parameter int STEP_W  = 2
) (
    input  logic [WIDTH-1:0]  count_i,
    input  logic [STEP_W-1:0] step_i,
    input  logic              up_down_i,
    input  logic              sat_i,
    output logic [WIDTH-1:0]  next_o,
    output logic              tc_o,
    output logic              step_illegal_o
);

    // Wide enough for count+step and count+MODULUS without overflow.
    localparam int CW = ((WIDTH > STEP_W) ? WIDTH : STEP_W) + 1;

    logic [CW-1:0] cnt_ext;
    logic [CW-1:0] stp_ext;
    logic [CW-1:0] mod_ext;
    logic [CW-1:0] res;

    assign cnt_ext = CW'(count_i);
    assign stp_ext = CW'(step_i);
    assign mod_ext = CW'(MODULUS);

    // Next count and terminal-count flag for the selected direction and mode.
    always_comb begin
        res            = cnt_ext;
        tc_o           = 1'b0;
        step_illegal_o = (stp_ext >= mod_ext);
        if (up_down_i == DIR_UP) begin
            if ((cnt_ext + stp_ext) >= mod_ext) begin
                if (sat_i == MODE_SAT) begin
                    res  = mod_ext - CW'(1);
                    tc_o = (cnt_ext != (mod_ext - CW'(1)));
                end else begin
                    res  = cnt_ext + stp_ext - mod_ext;
                    tc_o = 1'b1;
                end
            end else begin
                res = cnt_ext + stp_ext;
            end
        end else begin
            if (stp_ext > cnt_ext) begin
                if (sat_i == MODE_SAT) begin
                    res  = '0;
                    tc_o = (cnt_ext != '0);
                end else begin
                    res  = cnt_ext + mod_ext - stp_ext;
                    tc_o = 1'b1;
                end
            end else begin
                res = cnt_ext - stp_ext;
            end
        end
    end

    assign next_o = res[WIDTH-1:0];

endmodule

// File: rtl/modn_updown_counter.sv
// Modulo-N up/down counter with load, enable, programmable step and
// wrap/saturate mode. All outputs are registered. Defining MODN_WRAP_CNT_EN
// adds the wrap_count output, a free-running count of wrap events.
module modn_updown_counter
    import modn_counter_pkg::*;
#(
    parameter int WIDTH      = 4,
    parameter int MODULUS    = 14,
    parameter int STEP_W     = 2,
    parameter int WRAP_CNT_W = 8
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              en,
    input  logic              load,
    input  logic [WIDTH-1:0]  data_in,
    input  logic              up_down,
    input  logic [STEP_W-1:0] step,
    input  logic              sat,
    output logic [WIDTH-1:0]  count,
    output logic              tc,
    output logic              err
`ifdef MODN_WRAP_CNT_EN
    ,
    output logic [WRAP_CNT_W-1:0] wrap_count
`endif
);

    if (MODULUS < 2) begin : g_chk_mod_min
        $error("modn_updown_counter: MODULUS must be at least 2");
    end
    if (MODULUS > (2 ** WIDTH)) begin : g_chk_mod_max
        $error("modn_updown_counter: MODULUS must not exceed 2**WIDTH");
    end
    if (WRAP_CNT_W < 1) begin : g_chk_wrap_w
        $error("modn_updown_counter: WRAP_CNT_W must be at least 1");
    end

    logic [WIDTH-1:0] count_q, count_d;
    logic             tc_q, tc_d;
    logic             err_q, err_d;

    logic [WIDTH-1:0] calc_next;
    logic             calc_tc;
    logic             calc_step_ill;
    logic             load_ok;

    modn_next_calc #(
        .WIDTH   (WIDTH),
        .MODULUS (MODULUS),
        .STEP_W  (STEP_W)
    ) u_next (
        .count_i        (count_q),
        .step_i         (step),
        .up_down_i      (up_down),
        .sat_i          (sat),
        .next_o         (calc_next),
        .tc_o           (calc_tc),
        .step_illegal_o (calc_step_ill)
    );

    assign load_ok = modn_legal(32'(data_in), 32'(MODULUS));

    // Priority chain: legal load, then count (an illegal load still counts), hold.
    always_comb begin
        count_d = count_q;
        tc_d    = 1'b0;
        err_d   = 1'b0;
        if (load && load_ok) begin
            count_d = data_in;
        end else begin
            err_d = load;
            if (en) begin
                if (calc_step_ill) begin
                    err_d = 1'b1;
                end else if (step != '0) begin
                    count_d = calc_next;
                    tc_d    = calc_tc;
                end
            end
        end
    end

    // Count and event-pulse registers with synchronous active-low reset.
    always_ff @(posedge clock) begin
        if (!reset) begin
            count_q <= '0;
            tc_q    <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            count_q <= count_d;
            tc_q    <= tc_d;
            err_q   <= err_d;
        end
    end

    assign count = count_q;
    assign tc    = tc_q;
    assign err   = err_q;

`ifdef MODN_WRAP_CNT_EN
    logic [WRAP_CNT_W-1:0] wrap_cnt_q, wrap_cnt_d;

    // In wrap mode every terminal count is a wrap; saturation hits are not counted.
    always_comb begin
        wrap_cnt_d = wrap_cnt_q;
        if (tc_d && (sat == MODE_WRAP)) begin
            wrap_cnt_d = wrap_cnt_q + WRAP_CNT_W'(1);
        end
    end

    // Wrap-event counter, cleared only by reset and rolling over naturally.
    always_ff @(posedge clock) begin
        if (!reset) begin
            wrap_cnt_q <= '0;
        end else begin
            wrap_cnt_q <= wrap_cnt_d;
        end
    end

    assign wrap_count = wrap_cnt_q;
`endif

endmodule
